// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter: the CPU always wins, a second master (DMA) gets idle cycles.
// Read data is steered back to its issuer using registered owner bits.
module dmem_arbiter #(
  parameter int                 ADDR_W       = 16,
  parameter int                 DATA_W       = 8,
  parameter logic [ADDR_W-1:0]  DMEM_TOP     = 16'h0FFF,
  parameter int unsigned        STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              starve_clr,
  output logic              starved,
  output logic [7:0]        conflict_cnt
);

  typedef enum logic [0:0] {IDLE, WAIT} arbStateT;

  arbStateT          state;
  arbStateT          stateNext;
  logic              cpuHit;
  logic              dmaInRange;
  logic              dmaConflict;
  logic              dmaGnt;
  logic              leaveWait;
  logic              cpuRdD;
  logic              dmaRdD;
  logic              dmaOorD;
  logic [DATA_W-1:0] cpuHold;
  logic [DATA_W-1:0] dmaHold;
  logic [DATA_W-1:0] dmaRetData;
  logic [7:0]        waitCnt;
  logic [7:0]        waitCntInc;
  logic              starveSet;

  assign cpuHit      = (cpu_we | cpu_re) & (cpu_addr <= DMEM_TOP);
  assign dmaInRange  = (dma_addr <= DMEM_TOP);
  assign dmaConflict = dma_req & cpuHit;
  // I/O-space CPU accesses leave the RAM free, so only RAM hits block the DMA
  assign dmaGnt      = rst_n & dma_req & ~cpuHit;
  assign dma_gnt     = dmaGnt;
  assign dma_err     = dmaGnt & ~dmaInRange;

  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_wdata;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (rst_n) begin
      if (cpuHit) begin
        mem_we = cpu_we;
        mem_re = cpu_re;
      end else if (dma_req && dmaInRange) begin
        mem_addr = dma_addr;
        mem_din  = dma_wdata;
        mem_we   = dma_we;
        mem_re   = ~dma_we;
      end
    end
  end

  // Owner bits for the read issued last cycle; out-of-range DMA reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpuRdD  <= 1'b0;
      dmaRdD  <= 1'b0;
      dmaOorD <= 1'b0;
    end else begin
      cpuRdD  <= cpu_re & cpuHit;
      dmaRdD  <= dmaGnt & ~dma_we;
      dmaOorD <= dmaGnt & ~dma_we & ~dmaInRange;
    end
  end

  assign dmaRetData = dmaOorD ? '0 : mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpuHold <= '0;
      dmaHold <= '0;
    end else begin
      if (cpuRdD) cpuHold <= mem_dout;
      if (dmaRdD) dmaHold <= dmaRetData;
    end
  end

  assign cpu_rdata  = cpuRdD ? mem_dout : cpuHold;
  assign dma_rdata  = dmaRdD ? dmaRetData : dmaHold;
  assign dma_rvalid = dmaRdD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (dmaConflict) stateNext = WAIT;
      WAIT: if (dmaGnt || !dma_req) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    leaveWait  = (state == WAIT) && (stateNext == IDLE);
    waitCntInc = (waitCnt == 8'hFF) ? waitCnt : waitCnt + 8'd1;
    starveSet  = dmaConflict && (32'(waitCntInc) >= STARVE_LIMIT);
  end

  // A blocked cycle both enters and extends WAIT, so it always counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= 8'd0;
    end else if (dmaConflict) begin
      waitCnt <= waitCntInc;
    end else if (leaveWait) begin
      waitCnt <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starved <= 1'b0;
    end else if (starveSet) begin
      starved <= 1'b1;
    end else if (starve_clr) begin
      starved <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= 8'd0;
    end else if (dmaConflict && conflict_cnt != 8'hFF) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWdata;
  logic        cpuWe;
  logic        cpuRe;
  logic [7:0]  cpuRdata;
  logic        dmaReq;
  logic        dmaWe;
  logic [15:0] dmaAddr;
  logic [7:0]  dmaWdata;
  logic        dmaGnt;
  logic        dmaRvalid;
  logic [7:0]  dmaRdata;
  logic        dmaErr;
  logic [15:0] memAddr;
  logic [7:0]  memDin;
  logic        memWe;
  logic        memRe;
  logic [7:0]  memDout;
  logic        starveClr;
  logic        starved;
  logic [7:0]  conflictCnt;

  logic        ramInit;
  logic [7:0]  ram [0:4095];
  int          compared = 0;
  int          mismatched = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata), .cpu_we(cpuWe), .cpu_re(cpuRe),
    .cpu_rdata(cpuRdata),
    .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_gnt(dmaGnt), .dma_rvalid(dmaRvalid), .dma_rdata(dmaRdata), .dma_err(dmaErr),
    .mem_addr(memAddr), .mem_din(memDin), .mem_we(memWe), .mem_re(memRe),
    .mem_dout(memDout),
    .starve_clr(starveClr), .starved(starved), .conflict_cnt(conflictCnt)
  );

  always #5 clk = ~clk;

  // Registered-output RAM model, preloaded while ramInit is high
  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h005] <= 8'h55;
      ram[12'h010] <= 8'h11;
      ram[12'h020] <= 8'h22;
      memDout <= 8'h00;
    end else begin
      if (memWe) ram[memAddr[11:0]] <= memDin;
      if (memRe) memDout <= ram[memAddr[11:0]];
    end
  end

  task automatic applyStimulus(input logic [15:0] cA, input logic [7:0] cWd, input logic cW,
                               input logic cR, input logic dR, input logic dW,
                               input logic [15:0] dA, input logic [7:0] dWd);
    cpuAddr = cA; cpuWdata = cWd; cpuWe = cW; cpuRe = cR;
    dmaReq = dR; dmaWe = dW; dmaAddr = dA; dmaWdata = dWd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; ramInit = 1'b1; starveClr = 1'b0;
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
    @(negedge clk); #1;
    checkOutput("rst_gnt",      32'(dmaGnt),      32'h0);
    checkOutput("rst_mem_re",   32'(memRe),       32'h0);
    checkOutput("rst_mem_we",   32'(memWe),       32'h0);
    checkOutput("rst_rvalid",   32'(dmaRvalid),   32'h0);
    checkOutput("rst_err",      32'(dmaErr),      32'h0);
    checkOutput("rst_cpu_rd",   32'(cpuRdata),    32'h0);
    checkOutput("rst_dma_rd",   32'(dmaRdata),    32'h0);
    checkOutput("rst_starved",  32'(starved),     32'h0);
    checkOutput("rst_conflict", 32'(conflictCnt), 32'h0);
    ramInit = 1'b0;
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    rst_n = 1'b1;

    // Idle CPU: DMA write then read back
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0123, 8'h5A);
    #1;
    checkOutput("t1_wr_gnt",   32'(dmaGnt),  32'h1);
    checkOutput("t1_wr_we",    32'(memWe),   32'h1);
    checkOutput("t1_wr_addr",  32'(memAddr), 32'h0123);
    checkOutput("t1_wr_din",   32'(memDin),  32'h5A);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h00);
    #1;
    checkOutput("t1_rd_gnt",   32'(dmaGnt),  32'h1);
    checkOutput("t1_rd_re",    32'(memRe),   32'h1);
    checkOutput("t1_rd_we",    32'(memWe),   32'h0);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t1_rvalid",   32'(dmaRvalid), 32'h1);
    checkOutput("t1_rdata",    32'(dmaRdata),  32'h5A);
    tick(); #1;
    checkOutput("t1_rvalid_off", 32'(dmaRvalid), 32'h0);
    checkOutput("t1_rdata_hold", 32'(dmaRdata),  32'h5A);

    // CPU read and DMA read collide
    tick();
    applyStimulus(16'h0010, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
    #1;
    checkOutput("t2_c0_gnt",  32'(dmaGnt),  32'h0);
    checkOutput("t2_c0_addr", 32'(memAddr), 32'h0010);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00);
    #1;
    checkOutput("t2_c1_cpu_rdata", 32'(cpuRdata),    32'h11);
    checkOutput("t2_c1_gnt",       32'(dmaGnt),      32'h1);
    checkOutput("t2_c1_addr",      32'(memAddr),     32'h0020);
    checkOutput("t2_c1_rvalid",    32'(dmaRvalid),   32'h0);
    checkOutput("t2_conflict",     32'(conflictCnt), 32'h1);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t2_c2_rvalid",   32'(dmaRvalid), 32'h1);
    checkOutput("t2_c2_rdata",    32'(dmaRdata),  32'h22);
    checkOutput("t2_c2_cpu_hold", 32'(cpuRdata),  32'h11);

    // CPU in I/O space does not block the DMA
    tick();
    applyStimulus(16'h1001, 8'h77, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0005, 8'h00);
    #1;
    checkOutput("t3_gnt",      32'(dmaGnt),      32'h1);
    checkOutput("t3_mem_we",   32'(memWe),       32'h0);
    checkOutput("t3_mem_re",   32'(memRe),       32'h1);
    checkOutput("t3_mem_addr", 32'(memAddr),     32'h0005);
    checkOutput("t3_conflict", 32'(conflictCnt), 32'h1);
    tick();
    applyStimulus(16'h1001, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t3_rvalid", 32'(dmaRvalid), 32'h1);
    checkOutput("t3_rdata",  32'(dmaRdata),  32'h55);

    // Out-of-range DMA read
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2000, 8'h00);
    #1;
    checkOutput("t5_gnt",    32'(dmaGnt), 32'h1);
    checkOutput("t5_err",    32'(dmaErr), 32'h1);
    checkOutput("t5_mem_re", 32'(memRe),  32'h0);
    checkOutput("t5_mem_we", 32'(memWe),  32'h0);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t5_rvalid",  32'(dmaRvalid), 32'h1);
    checkOutput("t5_rdata",   32'(dmaRdata),  32'h00);
    checkOutput("t5_err_off", 32'(dmaErr),    32'h0);

    // Reset right after a DMA read grant cancels the return
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h00);
    #1;
    checkOutput("t6_gnt", 32'(dmaGnt), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t6_rvalid",   32'(dmaRvalid),   32'h0);
    checkOutput("t6_cpu_rd",   32'(cpuRdata),    32'h0);
    checkOutput("t6_dma_rd",   32'(dmaRdata),    32'h0);
    checkOutput("t6_conflict", 32'(conflictCnt), 32'h0);
    @(negedge clk); #1;
    checkOutput("t6_rvalid_hold", 32'(dmaRvalid), 32'h0);
    rst_n = 1'b1;
    tick();
    applyStimulus(16'h0010, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t6_post_re", 32'(memRe), 32'h1);
    tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t6_post_cpu_rdata", 32'(cpuRdata),  32'h11);
    checkOutput("t6_post_rvalid",    32'(dmaRvalid), 32'h0);

    // 70 blocked cycles: starvation sets after the 64th
    tick();
    applyStimulus(16'h0010, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0020, 8'h00);
    #1;
    checkOutput("t4_gnt", 32'(dmaGnt), 32'h0);
    for (int i = 0; i < 63; i++) tick();
    #1;
    checkOutput("t4_starved_63",  32'(starved),     32'h0);
    checkOutput("t4_conflict_63", 32'(conflictCnt), 32'd63);
    tick(); #1;
    checkOutput("t4_starved_64", 32'(starved),  32'h1);
    checkOutput("t4_gnt_64",     32'(dmaGnt),   32'h0);
    checkOutput("t4_cpu_rdata",  32'(cpuRdata), 32'h11);
    for (int i = 0; i < 6; i++) tick();
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    #1;
    checkOutput("t4_conflict_70", 32'(conflictCnt), 32'd70);
    checkOutput("t4_starved_70",  32'(starved),     32'h1);
    starveClr = 1'b1;
    tick();
    starveClr = 1'b0;
    #1;
    checkOutput("t4_starved_clr",  32'(starved),     32'h0);
    checkOutput("t4_conflict_end", 32'(conflictCnt), 32'd70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
